lvdc_checkout_driver: RTL and testbench

- Ground-checkout stimulus stage directly upstream of the LVDC top level.
- Generates the computer's external control and serial-data inputs: CSTN, DATAV, DIN, HALTV and TER.
- Accepts word-level commands through a valid/ready handshake, aligns them to the LVDC word and bit timing, and serializes 26-bit data words onto DIN, qualified by DATAV.
- Used by breadboard and full-system simulation benches, and by the future checkout-panel model.

---
 rtl/lvdc_ckt_pkg.sv | 30 +++
 rtl/lvdc_checkout_driver_if.sv | 10 +
 rtl/ckt_shift_reg.sv | 19 +
 rtl/lvdc_checkout_driver.sv | 162 ++++++++++++++++
 tb/tb_lvdc_checkout_driver.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/lvdc_ckt_pkg.sv
// Shared encodings and default sizes for the LVDC ground-checkout stimulus driver.
package lvdc_ckt_pkg;

    localparam int DEF_WORD_BITS = 26;
    localparam int DEF_CST_BITS  = 4;
    localparam int DEF_TER_BITS  = 1;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_START = 2'd1,
        OP_HALT  = 2'd2,
        OP_TERM  = 2'd3
    } ckt_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_SHIFT,
        ST_START,
        ST_TERM,
        ST_FINISH
    } ckt_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lvdc_checkout_driver_if.sv
// Command handshake between a checkout requester and the stimulus driver.
interface lvdc_checkout_driver_if #(parameter int WORD_BITS = 26);
    logic                 CMD_VALID;
    logic                 CMD_READY;
    logic [1:0]           CMD_OP;
    logic [WORD_BITS-1:0] CMD_DATA;

    modport master (output CMD_VALID, CMD_OP, CMD_DATA, input CMD_READY);
    modport slave  (input CMD_VALID, CMD_OP, CMD_DATA, output CMD_READY);
endinterface

// File: rtl/ckt_shift_reg.sv
// Word register: parallel load, LSB-first shift; bit_o is the bit due out next.
module ckt_shift_reg #(parameter int W = 26) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    input  logic         sh,
    output logic         bit_o
);
    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (ld) q <= d;
        else if (sh) q <= {1'b0, q[W-1:1]};
    end

    assign bit_o = q[0];
endmodule

// File: rtl/lvdc_checkout_driver.sv
// Turns word-level checkout commands into bit-timed CSTN/DATAV/DIN/HALTV/TER stimulus.
module lvdc_checkout_driver
    import lvdc_ckt_pkg::*;
#(
    parameter int WORD_BITS = DEF_WORD_BITS,
    parameter int CST_BITS  = DEF_CST_BITS,
    parameter int TER_BITS  = DEF_TER_BITS
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 BIT_STB,
    input  logic                 WORD_STB,
    lvdc_checkout_driver_if.slave cmd,
    output logic                 CSTN,
    output logic                 DATAV,
    output logic                 DIN,
    output logic                 HALTV,
    output logic                 TER,
    output logic                 BUSY,
    output logic                 DONE
);
    localparam int CW = $clog2(max3(WORD_BITS, CST_BITS, TER_BITS) + 1);
    localparam logic [CW-1:0] WB_C = CW'(WORD_BITS);
    localparam logic [CW-1:0] CB_C = CW'(CST_BITS);
    localparam logic [CW-1:0] TB_C = CW'(TER_BITS);

    ckt_state_t    state_q, state_d;
    ckt_op_t       op_q, op_in;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          cstn_d, datav_d, din_d, haltv_d, ter_d, busy_d, done_d;
    logic          accept, word_edge, bit_last, ld_en, sh_en, sr_bit;

    assign op_in     = ckt_op_t'(cmd.CMD_OP);
    assign accept    = cmd.CMD_VALID & ready_q;
    assign word_edge = BIT_STB & WORD_STB;
    assign cmd.CMD_READY = ready_q;

    // Final bit time of the active segment; count runs 1..N so N is the release strobe.
    assign bit_last = BIT_STB & (((state_q == ST_SHIFT) && (cnt_q == WB_C)) ||
                                 ((state_q == ST_START) && (cnt_q == CB_C)) ||
                                 ((state_q == ST_TERM)  && (cnt_q == TB_C)));

    ckt_shift_reg #(.W(WORD_BITS)) u_sr (
        .clk   (CLK),
        .rst_n (RSTN),
        .ld    (ld_en),
        .d     (cmd.CMD_DATA),
        .sh    (sh_en),
        .bit_o (sr_bit)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            CSTN    <= 1'b1;
            DATAV   <= 1'b0;
            DIN     <= 1'b0;
            HALTV   <= 1'b0;
            TER     <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) op_q <= op_in;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            CSTN    <= cstn_d;
            DATAV   <= datav_d;
            DIN     <= din_d;
            HALTV   <= haltv_d;
            TER     <= ter_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept && op_in != OP_HALT) state_d = ST_ALIGN;
            ST_ALIGN:
                if (word_edge) begin
                    unique case (op_q)
                        OP_LOAD:  state_d = ST_SHIFT;
                        OP_START: state_d = ST_START;
                        default:  state_d = ST_TERM;
                    endcase
                end
            ST_SHIFT,
            ST_START,
            ST_TERM:   if (bit_last) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cstn_d  = CSTN;
        datav_d = DATAV;
        din_d   = DIN;
        ter_d   = TER;
        cnt_d   = cnt_q;
        sh_en   = 1'b0;
        ld_en   = accept && (op_in == OP_LOAD);
        haltv_d = (accept && op_in == OP_HALT) ? cmd.CMD_DATA[0] : HALTV;
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        // DONE rides with the FINISH state, or follows a HALT accept directly.
        done_d  = (accept && op_in == OP_HALT) || (state_d == ST_FINISH);

        unique case (state_q)
            ST_ALIGN:
                if (word_edge) begin
                    cnt_d = CW'(1);
                    unique case (op_q)
                        OP_LOAD: begin
                            din_d   = sr_bit;
                            datav_d = 1'b1;
                            sh_en   = 1'b1;
                        end
                        OP_START: cstn_d = 1'b0;
                        default:  ter_d  = 1'b1;
                    endcase
                end
            ST_SHIFT:
                if (BIT_STB) begin
                    if (bit_last) begin
                        din_d   = 1'b0;
                        datav_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        din_d = sr_bit;
                        sh_en = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            ST_START:
                if (BIT_STB) begin
                    if (bit_last) begin
                        cstn_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            ST_TERM:
                if (BIT_STB) begin
                    if (bit_last) begin
                        ter_d = 1'b0;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lvdc_checkout_driver.sv
// Bench for lvdc_checkout_driver: segment-level model compared every cycle plus directed literal checks.
module tb_lvdc_checkout_driver;
    localparam int WB = 26;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic BIT_STB = 1'b0;
    logic WORD_STB = 1'b0;
    logic CSTN, DATAV, DIN, HALTV, TER, BUSY, DONE;

    lvdc_checkout_driver_if #(.WORD_BITS(WB)) cif ();

    lvdc_checkout_driver dut (
        .CLK(CLK), .RSTN(RSTN), .BIT_STB(BIT_STB), .WORD_STB(WORD_STB), .cmd(cif),
        .CSTN(CSTN), .DATAV(DATAV), .DIN(DIN), .HALTV(HALTV), .TER(TER),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a command occupies the driver from acceptance; its segment begins at the first
    // word boundary after acceptance and lasts N bit times; DONE marks the Nth strobe.
    bit          m_inflight = 0, m_started = 0, m_cool = 0, m_done = 0, m_haltv = 0;
    int          m_op = 0, m_bits = 0;
    logic [WB-1:0] m_data = '0;

    function automatic int nbits(input int op);
        return (op == 0) ? WB : (op == 1) ? 4 : 1;
    endfunction

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_inflight = 0; m_started = 0; m_cool = 0; m_done = 0; m_haltv = 0; m_bits = 0;
        end else begin
            m_done = 0;
            if (m_inflight) begin
                if (m_cool) begin
                    m_inflight = 0; m_cool = 0;
                end else if (!m_started) begin
                    if (BIT_STB && WORD_STB) begin m_started = 1; m_bits = 0; end
                end else if (BIT_STB) begin
                    m_bits++;
                    if (m_bits == nbits(m_op)) begin m_done = 1; m_cool = 1; end
                end
            end else if (cif.CMD_VALID) begin
                if (cif.CMD_OP == 2'd2) begin
                    m_haltv = cif.CMD_DATA[0];
                    m_done = 1;
                end else begin
                    m_inflight = 1; m_started = 0; m_cool = 0; m_bits = 0;
                    m_op = int'(cif.CMD_OP); m_data = cif.CMD_DATA;
                end
            end
        end
    end

    always @(negedge CLK) begin
        bit act;
        act = m_inflight && m_started && (m_bits < nbits(m_op));
        chk("CSTN",  32'(CSTN),  32'(!(act && m_op == 1)));
        chk("DATAV", 32'(DATAV), 32'(act && m_op == 0));
        chk("DIN",   32'(DIN),   32'((act && m_op == 0) ? m_data[m_bits] : 1'b0));
        chk("TER",   32'(TER),   32'(act && m_op == 3));
        chk("HALTV", 32'(HALTV), 32'(m_haltv));
        chk("BUSY",  32'(BUSY),  32'(m_inflight));
        chk("READY", 32'(cif.CMD_READY), 32'(!m_inflight));
        chk("DONE",  32'(DONE),  32'(m_done));
    end

    // Stimulus driver and output observers (observers look at the edge just passed).
    int cyc = 0;
    int n_datav = 0, n_cstn = 0, n_ter = 0, n_done = 0, ter_first = -1, cap_idx = 0;
    logic [WB-1:0] cap = '0;
    logic [WB-1:0] words[$];

    task automatic clear_obs();
        n_datav = 0; n_cstn = 0; n_ter = 0; n_done = 0; ter_first = -1; cap_idx = 0;
        words.delete();
    endtask

    task automatic tick();
        @(negedge CLK);
        if (DATAV) n_datav++;
        if (!CSTN) n_cstn++;
        if (TER) begin n_ter++; if (ter_first < 0) ter_first = cyc; end
        if (DONE) n_done++;
        if (BIT_STB && DATAV) begin
            cap[cap_idx] = DIN;
            cap_idx++;
            if (cap_idx == WB) begin words.push_back(cap); cap_idx = 0; end
        end
        cyc++;
        BIT_STB  = (cyc % 4 == 0);
        WORD_STB = (cyc % 104 == 0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [WB-1:0] d, output int acc);
        cif.CMD_VALID = 1'b1; cif.CMD_OP = op; cif.CMD_DATA = d;
        acc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (cif.CMD_READY) begin
                acc = cyc;
                tick();
                cif.CMD_VALID = 1'b0;
                return;
            end
            tick();
        end
        cif.CMD_VALID = 1'b0;
        chk("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (!BUSY && cif.CMD_READY) begin tick(); return; end
        end
        chk("idle_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int acc;
        cif.CMD_VALID = 1'b0; cif.CMD_OP = 2'd0; cif.CMD_DATA = '0;
        repeat (3) tick();
        chk("rst_cstn", 32'(CSTN), 32'(1));
        chk("rst_ready", 32'(cif.CMD_READY), 32'(1));
        chk("rst_busy", 32'(BUSY), 32'(0));
        RSTN = 1'b1;
        repeat (2) tick();

        // HALT=1, LOAD alternating word, HALT=0
        clear_obs();
        issue(2'd2, 26'd1, acc);
        tick();
        chk("halt1_done", 32'(n_done), 32'(1));
        chk("halt1_ready", 32'(cif.CMD_READY), 32'(1));
        chk("halt1_level", 32'(HALTV), 32'(1));
        clear_obs();
        issue(2'd0, 26'h2AAAAAA, acc);
        wait_idle();
        chk("load_words", 32'(words.size()), 32'(1));
        if (words.size() >= 1) chk("load_word0", 32'(words[0]), 32'h2AAAAAA);
        chk("load_datav_cycles", 32'(n_datav), 32'(104));
        chk("load_done", 32'(n_done), 32'(1));
        chk("load_haltv", 32'(HALTV), 32'(1));
        clear_obs();
        issue(2'd2, 26'd0, acc);
        tick();
        chk("halt0_level", 32'(HALTV), 32'(0));
        chk("halt0_done", 32'(n_done), 32'(1));

        // START
        clear_obs();
        issue(2'd1, 26'd0, acc);
        wait_idle();
        chk("start_cstn_cycles", 32'(n_cstn), 32'(16));
        chk("start_done", 32'(n_done), 32'(1));
        chk("start_haltv", 32'(HALTV), 32'(0));

        // Two LOADs with VALID held across the first
        clear_obs();
        issue(2'd0, 26'h1234567, acc);
        issue(2'd0, 26'h0ABCDEF, acc);
        wait_idle();
        chk("b2b_words", 32'(words.size()), 32'(2));
        if (words.size() >= 2) begin
            chk("b2b_word0", 32'(words[0]), 32'h1234567);
            chk("b2b_word1", 32'(words[1]), 32'h0ABCDEF);
        end
        chk("b2b_datav_cycles", 32'(n_datav), 32'(208));
        chk("b2b_done", 32'(n_done), 32'(2));

        // TERMINATE accepted on a WORD_STB edge: that strobe is skipped
        for (int i = 0; i < 200 && !WORD_STB; i++) tick();
        clear_obs();
        issue(2'd3, 26'd0, acc);
        wait_idle();
        chk("term_ter_cycles", 32'(n_ter), 32'(4));
        chk("term_delay", 32'(ter_first - acc), 32'(104));
        chk("term_done", 32'(n_done), 32'(1));

        // Asynchronous reset in the middle of a LOAD
        issue(2'd2, 26'd1, acc);
        clear_obs();
        issue(2'd0, 26'h3C3C3C3, acc);
        for (int i = 0; i < 1000 && cap_idx < 10; i++) tick();
        chk("mid_bit_reached", 32'(cap_idx), 32'(10));
        #3 RSTN = 1'b0;
        #1;
        chk("arst_cstn", 32'(CSTN), 32'(1));
        chk("arst_datav", 32'(DATAV), 32'(0));
        chk("arst_din", 32'(DIN), 32'(0));
        chk("arst_haltv", 32'(HALTV), 32'(0));
        chk("arst_ter", 32'(TER), 32'(0));
        chk("arst_ready", 32'(cif.CMD_READY), 32'(1));
        chk("arst_busy", 32'(BUSY), 32'(0));
        tick();
        RSTN = 1'b1;
        tick();
        clear_obs();
        issue(2'd0, 26'h155AA55, acc);
        wait_idle();
        chk("post_rst_words", 32'(words.size()), 32'(1));
        if (words.size() >= 1) chk("post_rst_word", 32'(words[0]), 32'h155AA55);
        chk("post_rst_done", 32'(n_done), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
